// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory command encodings, fetch state enum, instruction width.
// The fetch state set grows by PAUSE when SINGLE_STEP_EN is defined.
package cpu_pkg;

   localparam int INSTR_W = 16;

   typedef enum logic [1:0] {
      MNONE  = 2'b00,
      MREAD  = 2'b01,
      MWRITE = 2'b10
   } mem_cmd_t;

`ifdef SINGLE_STEP_EN
   typedef enum logic [2:0] {
      ST_RST, ST_FETCH, ST_LOAD_IR, ST_DISPATCH, ST_WAIT_EXEC, ST_HALT, ST_PAUSE
   } fetch_state_t;
`else
   typedef enum logic [2:0] {
      ST_RST, ST_FETCH, ST_LOAD_IR, ST_DISPATCH, ST_WAIT_EXEC, ST_HALT
   } fetch_state_t;
`endif

endpackage

// File: rtl/fetch_lat_cnt.sv
// Memory-latency down-counter for the fetch sequencer: loaded with LOAD_VAL on FETCH
// entry, decremented each FETCH cycle; zero_o marks the edge on which the count hits zero.
module fetch_lat_cnt #(
   parameter int CNT_W    = 4,
   parameter int LOAD_VAL = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic load_i,
   input  logic dec_i,
   output logic zero_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = CNT_W'(LOAD_VAL);
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign zero_o = dec_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns PC and IR, issues memory reads and hands one
// instruction at a time to execute. Optional SINGLE_STEP_EN adds step_go and a PAUSE state.
//
// state        | meaning
// RST          | first cycle after reset release
// FETCH        | MREAD on pc, waiting MEM_LAT cycles
// LOAD_IR      | capture mem_rdata into instr, pc advances
// DISPATCH     | exec_start pulse
// WAIT_EXEC    | waiting for exec_done (branch / halt applied here)
// HALT         | stopped until reset
// PAUSE        | single-step only: waiting for step_go
module fetch_sequencer
   import cpu_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter int              MEM_LAT  = 1,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   output logic [1:0]         mem_cmd,
   output logic [PC_W-1:0]    mem_addr,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    pc,
   output logic               exec_start,
   input  logic               exec_done,
   input  logic               pc_load,
   input  logic [PC_W-1:0]    pc_next,
   input  logic               halt_req,
`ifdef SINGLE_STEP_EN
   input  logic               step_go,
`endif
   output logic               halted
);

   fetch_state_t         state_q, state_d;
   logic [PC_W-1:0]      pc_q, pc_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   mem_cmd_t             mem_cmd_q, mem_cmd_d;
   logic                 exec_start_q, halted_q;
   logic                 lat_load, lat_dec, lat_zero;

   fetch_lat_cnt #(
      .CNT_W    (4),
      .LOAD_VAL (MEM_LAT)
   ) u_lat_cnt (
      .clk    (clk),
      .reset  (reset),
      .load_i (lat_load),
      .dec_i  (lat_dec),
      .zero_o (lat_zero)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      case (state_q)
         ST_RST:      state_d = ST_FETCH;
         ST_FETCH:    if (lat_zero) state_d = ST_LOAD_IR;
         ST_LOAD_IR: begin
            instr_d = mem_rdata;
            pc_d    = pc_q + PC_W'(1);
            state_d = ST_DISPATCH;
         end
         ST_DISPATCH: state_d = ST_WAIT_EXEC;
         ST_WAIT_EXEC: begin
            if (exec_done) begin
               if (pc_load) pc_d = pc_next;
               if (halt_req)
                  state_d = ST_HALT;
               else
`ifdef SINGLE_STEP_EN
                  state_d = ST_PAUSE;
`else
                  state_d = ST_FETCH;
`endif
            end
         end
`ifdef SINGLE_STEP_EN
         ST_PAUSE:    if (step_go) state_d = ST_FETCH;
`endif
         ST_HALT:     state_d = ST_HALT;
         default:     state_d = ST_RST;
      endcase
   end

   assign lat_load = (state_d == ST_FETCH) && (state_q != ST_FETCH);
   assign lat_dec  = (state_q == ST_FETCH);

   // Outputs registered from the next state so they change cleanly on the edge.
   always_comb begin
      mem_cmd_d = MNONE;
      if ((state_d == ST_FETCH) || (state_d == ST_LOAD_IR))
         mem_cmd_d = MREAD;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_RST;
         pc_q         <= RESET_PC;
         instr_q      <= '0;
         mem_cmd_q    <= MNONE;
         exec_start_q <= 1'b0;
         halted_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         mem_cmd_q    <= mem_cmd_d;
         exec_start_q <= (state_d == ST_DISPATCH);
         halted_q     <= (state_d == ST_HALT);
      end
   end

   assign mem_cmd    = mem_cmd_q;
   assign mem_addr   = pc_q;
   assign pc         = pc_q;
   assign instr      = instr_q;
   assign exec_start = exec_start_q;
   assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected fetches are queued when execute completes
// and checked at each exec_start, alongside read-timing checks against a memory model.
module tb_fetch_sequencer;
   import cpu_pkg::*;

   localparam int LAT = 3;

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] ins;
      logic [7:0]  pc;
   } fetch_exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  mem_cmd;
   logic [7:0]  mem_addr;
   logic [15:0] mem_rdata = 16'hDEAD;
   logic [15:0] instr;
   logic [7:0]  pc;
   logic        exec_start;
   logic        exec_done = 1'b0;
   logic        pc_load = 1'b0;
   logic [7:0]  pc_next = 8'h00;
   logic        halt_req = 1'b0;
   logic        step_go = 1'b0;
   logic        halted;

   logic [15:0] mem [256];
   fetch_exp_t  sb[$];
   logic [7:0]  model_pc;
   logic [7:0]  rd_addr;
   int          rd_run = 0;
   logic        prev_start = 1'b0;
   int          dispatches = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   fetch_sequencer #(
      .PC_W     (8),
      .MEM_LAT  (LAT),
      .RESET_PC (8'h00)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_cmd    (mem_cmd),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .instr      (instr),
      .pc         (pc),
      .exec_start (exec_start),
      .exec_done  (exec_done),
      .pc_load    (pc_load),
      .pc_next    (pc_next),
      .halt_req   (halt_req),
`ifdef SINGLE_STEP_EN
      .step_go    (step_go),
`endif
      .halted     (halted)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Memory model and read/dispatch monitor; data is only valid LAT cycles after MREAD starts.
   always @(negedge clk) begin
      if (reset) begin
         rd_run     = 0;
         prev_start = 1'b0;
         mem_rdata  = 16'hDEAD;
      end else begin
         if (mem_cmd == MREAD) begin
            if (rd_run == 0) rd_addr = mem_addr;
            else check_val("read_addr_stable", 32'(mem_addr), 32'(rd_addr));
            rd_run++;
            mem_rdata = (rd_run > LAT) ? mem[mem_addr] : 16'hDEAD;
         end else begin
            mem_rdata = 16'hDEAD;
            if (rd_run > 0) begin
               check_val("read_len", 32'(rd_run), 32'(LAT + 1));
               check_val("start_after_read", 32'(exec_start), 32'd1);
               rd_run = 0;
            end
         end
         if (exec_start) begin
            check_val("start_pulse_width", 32'(prev_start), 32'd0);
            if (sb.size() == 0) begin
               check_val("unexpected_dispatch", 32'(sb.size()), 32'd1);
            end else begin
               fetch_exp_t e;
               e = sb.pop_front();
               check_val("fetch_addr", 32'(rd_addr), 32'(e.addr));
               check_val("instr", 32'(instr), 32'(e.ins));
               check_val("pc_after_load", 32'(pc), 32'(e.pc));
               dispatches++;
            end
         end
         prev_start = exec_start;
      end
   end

   task automatic push_fetch(input logic [7:0] addr);
      fetch_exp_t e;
      e.addr = addr;
      e.ins  = mem[addr];
      e.pc   = addr + 8'd1;
      sb.push_back(e);
      model_pc = addr + 8'd1;
   endtask

   task automatic wait_dispatch(input string tag);
      int start_cnt;
      bit seen;
      start_cnt = dispatches;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         #1;
         if (dispatches != start_cnt) seen = 1'b1;
      end
      check_val({tag, "_dispatch_seen"}, 32'(seen), 32'd1);
   endtask

   // Called in the DISPATCH cycle; completes execute after wait_cyc WAIT_EXEC cycles.
   task automatic do_exec(input int wait_cyc, input int hold, input bit ld,
                          input logic [7:0] tgt, input bit hlt);
      @(posedge clk);
      repeat (wait_cyc) @(posedge clk);
      #1;
      exec_done = 1'b1;
      pc_load   = ld;
      pc_next   = tgt;
      halt_req  = hlt;
      if (ld) model_pc = tgt;
      if (!hlt) push_fetch(model_pc);
      repeat (hold) @(posedge clk);
      #1;
      exec_done = 1'b0;
      pc_load   = 1'b0;
      halt_req  = 1'b0;
`ifdef SINGLE_STEP_EN
      if (!hlt) begin
         repeat (4) begin
            @(negedge clk);
            #1;
            check_val("pause_idle", 32'(mem_cmd), 32'(MNONE));
         end
         step_go = 1'b1;
         @(posedge clk);
         #1;
         step_go = 1'b0;
      end
`endif
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_mem_cmd"}, 32'(mem_cmd), 32'(MNONE));
      check_val({tag, "_pc"}, 32'(pc), 32'h00);
      check_val({tag, "_instr"}, 32'(instr), 32'h0000);
      check_val({tag, "_exec_start"}, 32'(exec_start), 32'd0);
      check_val({tag, "_halted"}, 32'(halted), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0101) ^ 16'h3C5A;
      mem[0] = 16'hD105;
      model_pc = 8'h00;

      #1;
      check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      push_fetch(8'h00);
      #1;
      check_val("rst_state_no_read", 32'(mem_cmd), 32'(MNONE));
      wait_dispatch("first");

      // exec_done/halt_req/pc_load during DISPATCH must be ignored
      exec_done = 1'b1;
      halt_req  = 1'b1;
      pc_load   = 1'b1;
      pc_next   = 8'h77;
      @(posedge clk);
      #1;
      exec_done = 1'b0;
      halt_req  = 1'b0;
      pc_load   = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      check_val("dispatch_done_ignored_halt", 32'(halted), 32'd0);
      check_val("dispatch_done_ignored_pc", 32'(pc), 32'h01);
      check_val("dispatch_done_ignored_cmd", 32'(mem_cmd), 32'(MNONE));

      // exec_done held 3 cycles: one fetch at addr 1
      do_exec(0, 3, 1'b0, 8'h00, 1'b0);
      wait_dispatch("held_done");
      repeat (8) @(negedge clk);
      #1;
      check_val("held_done_no_double", 32'(sb.size()), 32'd0);

      do_exec(2, 1, 1'b1, 8'h40, 1'b0);
      wait_dispatch("branch_40");
      do_exec(1, 1, 1'b1, 8'hFF, 1'b0);
      wait_dispatch("fetch_ff");
      do_exec(0, 1, 1'b0, 8'h00, 1'b0);
      wait_dispatch("wrap_00");

      // halt with simultaneous branch
      do_exec(1, 1, 1'b1, 8'h10, 1'b1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         check_val("halt_cmd", 32'(mem_cmd), 32'(MNONE));
         if (i == 5) exec_done = 1'b1;
         if (i == 7) exec_done = 1'b0;
      end
      check_val("halted", 32'(halted), 32'd1);
      check_val("halt_pc", 32'(pc), 32'h10);
      check_val("halt_no_dispatch", 32'(sb.size()), 32'd0);

      reset = 1'b1;
      #1;
      check_reset_outputs("halt_reset");
      @(negedge clk);
      reset = 1'b0;
      push_fetch(8'h00);
      wait_dispatch("after_halt");

      // async reset in the middle of FETCH
      do_exec(0, 1, 1'b1, 8'h22, 1'b0);
      for (int i = 0; i < 20 && mem_cmd != MREAD; i++) begin
         @(negedge clk);
         #1;
      end
      check_val("mid_fetch_reached", 32'(mem_cmd), 32'(MREAD));
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      sb.delete();
      repeat (4) @(negedge clk);
      #1;
      check_val("async_reset_no_start", 32'(exec_start), 32'd0);
      reset = 1'b0;
      push_fetch(8'h00);
      wait_dispatch("after_async");
      do_exec(0, 1, 1'b0, 8'h00, 1'b0);
      wait_dispatch("after_async_next");

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
